// File: rtl/tcm_port_arbiter_pkg.sv
// Shared widths and FSM state encoding for the TCM port arbiter.
package tcm_port_arbiter_pkg;

  localparam int unsigned TCM_ADDR_W = 14;
  localparam int unsigned TCM_DATA_W = 64;

  // Zero-fill after reset, then a terminal run state.
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } tcm_state_e;

endpackage

// File: rtl/tcm_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention
// the requester that was not granted last wins. Pointer moves only on a grant.
module tcm_port_arbiter_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = requester B (bit 1) was granted last, so A is favoured next.
  logic last_q;

  // Pointer register; reset favours A.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= grant[1];
    end
  end

  // Grant selection.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Shares one TCM RAM port between the core data side (A) and the external
// loader/debug side (B). Zero-fills the RAM after reset, then grants one
// access per cycle round-robin and returns ack/read data one cycle later.
module tcm_port_arbiter
  import tcm_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = TCM_ADDR_W,
  parameter int unsigned DATA_W        = TCM_DATA_W,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  a_rd_i,
  input  logic [DATA_W/8-1:0]   a_wr_i,
  input  logic [ADDR_W-1:0]     a_addr_i,
  input  logic [DATA_W-1:0]     a_data_wr_i,
  output logic                  a_accept_o,
  output logic                  a_ack_o,
  output logic [DATA_W-1:0]     a_data_rd_o,

  input  logic                  b_rd_i,
  input  logic [DATA_W/8-1:0]   b_wr_i,
  input  logic [ADDR_W-1:0]     b_addr_i,
  input  logic [DATA_W-1:0]     b_data_wr_i,
  output logic                  b_accept_o,
  output logic                  b_ack_o,
  output logic [DATA_W-1:0]     b_data_rd_o,

  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W-1:0]     ram_data_o,
  output logic [DATA_W/8-1:0]   ram_wr_o,
  input  logic [DATA_W-1:0]     ram_data_i,

  output logic                  init_busy_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  tcm_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          req;
  logic [1:0]          grant;
  logic                run;
  logic                pend_valid_q;
  logic                pend_owner_q;   // 0 = A, 1 = B

  assign run = (state_q == S_RUN) && !rst_i;
  assign req = {b_rd_i | (|b_wr_i), a_rd_i | (|a_wr_i)} & {2{run}};

  tcm_port_arbiter_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req),
    .advance (|grant),
    .grant   (grant)
  );

  // FSM state and zero-fill counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT_ON_RESET ? S_INIT : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and RAM-port / accept muxing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_addr_o = '0;
    ram_data_o = '0;
    ram_wr_o   = '0;
    a_accept_o = 1'b0;
    b_accept_o = 1'b0;

    case (state_q)
      S_INIT: begin
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
        if (!rst_i) begin
          ram_addr_o = cnt_q;
          ram_wr_o   = {STRB_W{1'b1}};
        end
      end
      S_RUN: begin
        if (grant[0]) begin
          a_accept_o = 1'b1;
          ram_addr_o = a_addr_i;
          ram_data_o = a_data_wr_i;
          ram_wr_o   = a_wr_i;
        end else if (grant[1]) begin
          b_accept_o = 1'b1;
          ram_addr_o = b_addr_i;
          ram_data_o = b_data_wr_i;
          ram_wr_o   = b_wr_i;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Remember who was granted so the ack lands on the right requester.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
    end else begin
      pend_valid_q <= |grant;
      pend_owner_q <= grant[1];
    end
  end

  // Ack routing; an in-flight ack is dropped while reset is asserted.
  assign a_ack_o     = pend_valid_q & ~pend_owner_q & ~rst_i;
  assign b_ack_o     = pend_valid_q &  pend_owner_q & ~rst_i;
  assign a_data_rd_o = a_ack_o ? ram_data_i : '0;
  assign b_data_rd_o = b_ack_o ? ram_data_i : '0;

  assign init_busy_o = rst_i ? INIT_ON_RESET : (state_q == S_INIT);

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter with a behavioural read-first RAM.
module tb_tcm_port_arbiter;

  logic        clk;
  logic        rst;
  logic        a_rd, b_rd;
  logic [7:0]  a_wr, b_wr;
  logic [13:0] a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;
  logic        a_accept, b_accept, a_ack, b_ack;
  logic [63:0] a_rdata, b_rdata;
  logic [13:0] ram_addr;
  logic [63:0] ram_wdata, ram_rdata;
  logic [7:0]  ram_wr;
  logic        init_busy;
  logic        fill_junk;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [0:16383];

  tcm_port_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .a_rd_i      (a_rd),
    .a_wr_i      (a_wr),
    .a_addr_i    (a_addr),
    .a_data_wr_i (a_wdata),
    .a_accept_o  (a_accept),
    .a_ack_o     (a_ack),
    .a_data_rd_o (a_rdata),
    .b_rd_i      (b_rd),
    .b_wr_i      (b_wr),
    .b_addr_i    (b_addr),
    .b_data_wr_i (b_wdata),
    .b_accept_o  (b_accept),
    .b_ack_o     (b_ack),
    .b_data_rd_o (b_rdata),
    .ram_addr_o  (ram_addr),
    .ram_data_o  (ram_wdata),
    .ram_wr_o    (ram_wr),
    .ram_data_i  (ram_rdata),
    .init_busy_o (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read-first port with byte writes; can be preloaded with junk.
  always @(posedge clk) begin
    if (fill_junk) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 64'hA5A5_0000_0000_0001 + 64'(i);
    end else begin
      ram_rdata <= mem[ram_addr];
      for (int k = 0; k < 8; k++)
        if (ram_wr[k]) mem[ram_addr][k*8 +: 8] <= ram_wdata[k*8 +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
    b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic test_reset_init();
    int bad;
    int first_bad;
    bad = 0;
    first_bad = -1;
    rst = 1; fill_junk = 1; idle_inputs();
    tick();
    fill_junk = 0;
    a_rd = 1; a_addr = 14'h1234;
    #1;
    checks++;
    if (init_busy !== 1'b1 || a_accept !== 1'b0 || a_ack !== 1'b0 || ram_wr !== 8'h00 || ram_addr !== 14'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b acc=%b ack=%b wr=%h addr=%h required 1 0 0 00 0000",
               init_busy, a_accept, a_ack, ram_wr, ram_addr);
    end
    tick();
    rst = 0;
    for (int i = 0; i < 16384; i++) begin
      #1;
      if (init_busy !== 1'b1 || ram_wr !== 8'hFF || ram_addr !== 14'(i) || ram_wdata !== 64'h0 ||
          a_accept !== 1'b0 || a_ack !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL init_sweep bad_cycles=%0d first_bad=%0d required 0", bad, first_bad);
    end
    #1;
    checks++;
    if (init_busy !== 1'b0 || a_accept !== 1'b1 || ram_addr !== 14'h1234 || ram_wr !== 8'h00) begin
      errors++;
      $display("FAIL init_exit busy=%b acc=%b addr=%h wr=%h required 0 1 1234 00",
               init_busy, a_accept, ram_addr, ram_wr);
    end
    tick();
    a_rd = 0;
    #1;
    checks++;
    if (a_ack !== 1'b1 || a_rdata !== 64'h0) begin
      errors++;
      $display("FAIL read_after_init ack=%b data=%h required 1 0", a_ack, a_rdata);
    end
    tick();
  endtask

  task automatic test_byte_write();
    a_wr = 8'h0F; a_addr = 14'h10; a_wdata = 64'hDEADBEEF_CAFEF00D;
    #1;
    checks++;
    if (a_accept !== 1'b1 || ram_wr !== 8'h0F || ram_addr !== 14'h10 || ram_wdata !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL byte_write_issue acc=%b wr=%h addr=%h data=%h", a_accept, ram_wr, ram_addr, ram_wdata);
    end
    tick();
    a_wr = 0; a_rd = 1;
    #1;
    checks++;
    if (a_ack !== 1'b1 || a_accept !== 1'b1 || ram_wr !== 8'h00) begin
      errors++;
      $display("FAIL write_ack ack=%b acc=%b wr=%h required 1 1 00", a_ack, a_accept, ram_wr);
    end
    tick();
    a_rd = 0;
    #1;
    checks++;
    if (a_ack !== 1'b1 || a_rdata !== 64'h00000000_CAFEF00D) begin
      errors++;
      $display("FAIL byte_write_read ack=%b data=%h required 1 00000000cafef00d", a_ack, a_rdata);
    end
    tick();
    #1;
    checks++;
    if (a_ack !== 1'b0 || a_rdata !== 64'h0 || ram_wr !== 8'h00) begin
      errors++;
      $display("FAIL idle_outputs ack=%b data=%h wr=%h required 0 0 00", a_ack, a_rdata, ram_wr);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic prev_b;
    logic exp_a;
    b_rd = 1; b_addr = 14'h1234;
    #1;
    checks++;
    if (b_accept !== 1'b1 || a_accept !== 1'b0 || ram_addr !== 14'h1234) begin
      errors++;
      $display("FAIL b_alone b_acc=%b a_acc=%b addr=%h required 1 0 1234", b_accept, a_accept, ram_addr);
    end
    tick();
    prev_b = 1;
    a_rd = 1; a_addr = 14'h10;
    for (int c = 0; c < 8; c++) begin
      exp_a = (c % 2 == 0);
      #1;
      checks++;
      if (a_accept !== exp_a || b_accept !== !exp_a || a_ack !== !prev_b || b_ack !== prev_b ||
          a_rdata !== (prev_b ? 64'h0 : 64'h00000000_CAFEF00D) || b_rdata !== 64'h0) begin
        errors++;
        $display("FAIL rr_cycle%0d a_acc=%b b_acc=%b a_ack=%b b_ack=%b a_data=%h b_data=%h exp_a_win=%b",
                 c, a_accept, b_accept, a_ack, b_ack, a_rdata, b_rdata, exp_a);
      end
      prev_b = !exp_a;
      tick();
    end
    a_rd = 0; b_rd = 0;
    #1;
    checks++;
    if (b_ack !== 1'b1 || a_ack !== 1'b0 || a_accept !== 1'b0 || b_accept !== 1'b0) begin
      errors++;
      $display("FAIL rr_tail a_ack=%b b_ack=%b a_acc=%b b_acc=%b required 0 1 0 0", a_ack, b_ack, a_accept, b_accept);
    end
    tick();
  endtask

  task automatic test_late_b();
    int bad;
    bad = 0;
    a_rd = 1; a_addr = 14'h10;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (a_accept !== 1'b1 || b_accept !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL a_stream bad_cycles=%0d required 0", bad);
    end
    b_rd = 1; b_addr = 14'h1234;
    #1;
    checks++;
    if (b_accept !== 1'b1 || a_accept !== 1'b0 || a_ack !== 1'b1) begin
      errors++;
      $display("FAIL b_arrives b_acc=%b a_acc=%b a_ack=%b required 1 0 1", b_accept, a_accept, a_ack);
    end
    tick();
    b_rd = 0;
    #1;
    checks++;
    if (a_accept !== 1'b1 || b_ack !== 1'b1 || a_ack !== 1'b0) begin
      errors++;
      $display("FAIL a_resumes a_acc=%b b_ack=%b a_ack=%b required 1 1 0", a_accept, b_ack, a_ack);
    end
    tick();
    a_rd = 0;
    tick();
  endtask

  task automatic test_read_first();
    a_wr = 8'hFF; a_addr = 14'h20; a_wdata = 64'h1111_1111_1111_1111;
    #1;
    tick();
    a_rd = 1; a_wdata = 64'h2222_2222_2222_2222;
    #1;
    checks++;
    if (a_accept !== 1'b1 || ram_wr !== 8'hFF || ram_wdata !== 64'h2222_2222_2222_2222) begin
      errors++;
      $display("FAIL rdwr_issue acc=%b wr=%h data=%h", a_accept, ram_wr, ram_wdata);
    end
    tick();
    a_rd = 1; a_wr = 0;
    #1;
    checks++;
    if (a_ack !== 1'b1 || a_rdata !== 64'h1111_1111_1111_1111) begin
      errors++;
      $display("FAIL read_first_old ack=%b data=%h required 1 1111111111111111", a_ack, a_rdata);
    end
    tick();
    a_rd = 0;
    #1;
    checks++;
    if (a_ack !== 1'b1 || a_rdata !== 64'h2222_2222_2222_2222) begin
      errors++;
      $display("FAIL read_first_new ack=%b data=%h required 1 2222222222222222", a_ack, a_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    n = 0;
    bad = 0;
    a_rd = 1; a_addr = 14'h20;
    #1;
    checks++;
    if (a_accept !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept acc=%b required 1", a_accept);
    end
    tick();
    a_rd = 0; rst = 1;
    #1;
    checks++;
    if (a_ack !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL ack_dropped ack=%b busy=%b required 0 1", a_ack, init_busy);
    end
    tick();
    rst = 0; a_rd = 1;
    while (n < 20000) begin
      #1;
      if (init_busy !== 1'b1) break;
      if (a_accept !== 1'b0 || a_ack !== 1'b0) bad++;
      n++;
      tick();
    end
    checks++;
    if (n !== 16384 || bad !== 0) begin
      errors++;
      $display("FAIL reinit busy_cycles=%0d bad=%0d required 16384 0", n, bad);
    end
    checks++;
    if (a_accept !== 1'b1) begin
      errors++;
      $display("FAIL accept_after_reinit acc=%b required 1", a_accept);
    end
    tick();
    a_rd = 0;
    #1;
    checks++;
    if (a_ack !== 1'b1 || a_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reread_zeroed ack=%b data=%h required 1 0", a_ack, a_rdata);
    end
    tick();
  endtask

  initial begin
    rst = 1;
    fill_junk = 0;
    idle_inputs();
    test_reset_init();
    test_byte_write();
    test_round_robin();
    test_late_b();
    test_read_first();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
